// File: rtl/npn4_canon_search.sv
// Sequential NPN canonicaliser for 4-input functions: one (perm, neg-mask) step per cycle,
// both output polarities per step, smallest truth table wins with earliest-candidate tie-break.
module npn4_canon_search (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] in_tt,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [15:0] out_tt,
  output logic [4:0]  out_perm,
  output logic [3:0]  out_ineg,
  output logic        out_oneg,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        busy
);

  localparam logic [8:0] LAST_STEP = 9'd383;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SEARCH = 2'd1,
    DONE   = 2'd2
  } state_t;

  // Tuple (pi0,pi1,pi2,pi3) packed with pi0 in the top two bits, lexicographic rank p.
  function automatic logic [7:0] perm_tuple(input logic [4:0] p);
    logic [7:0] t;
    case (p)
      5'd0:    t = {2'd0, 2'd1, 2'd2, 2'd3};
      5'd1:    t = {2'd0, 2'd1, 2'd3, 2'd2};
      5'd2:    t = {2'd0, 2'd2, 2'd1, 2'd3};
      5'd3:    t = {2'd0, 2'd2, 2'd3, 2'd1};
      5'd4:    t = {2'd0, 2'd3, 2'd1, 2'd2};
      5'd5:    t = {2'd0, 2'd3, 2'd2, 2'd1};
      5'd6:    t = {2'd1, 2'd0, 2'd2, 2'd3};
      5'd7:    t = {2'd1, 2'd0, 2'd3, 2'd2};
      5'd8:    t = {2'd1, 2'd2, 2'd0, 2'd3};
      5'd9:    t = {2'd1, 2'd2, 2'd3, 2'd0};
      5'd10:   t = {2'd1, 2'd3, 2'd0, 2'd2};
      5'd11:   t = {2'd1, 2'd3, 2'd2, 2'd0};
      5'd12:   t = {2'd2, 2'd0, 2'd1, 2'd3};
      5'd13:   t = {2'd2, 2'd0, 2'd3, 2'd1};
      5'd14:   t = {2'd2, 2'd1, 2'd0, 2'd3};
      5'd15:   t = {2'd2, 2'd1, 2'd3, 2'd0};
      5'd16:   t = {2'd2, 2'd3, 2'd0, 2'd1};
      5'd17:   t = {2'd2, 2'd3, 2'd1, 2'd0};
      5'd18:   t = {2'd3, 2'd0, 2'd1, 2'd2};
      5'd19:   t = {2'd3, 2'd0, 2'd2, 2'd1};
      5'd20:   t = {2'd3, 2'd1, 2'd0, 2'd2};
      5'd21:   t = {2'd3, 2'd1, 2'd2, 2'd0};
      5'd22:   t = {2'd3, 2'd2, 2'd0, 2'd1};
      5'd23:   t = {2'd3, 2'd2, 2'd1, 2'd0};
      default: t = {2'd0, 2'd1, 2'd2, 2'd3};
    endcase
    return t;
  endfunction

  // g[m] = f[m'] with m'[i] = m[pi_i] ^ n[i]; output polarity is applied by the caller.
  function automatic logic [15:0] npn_apply(input logic [15:0] f, input logic [7:0] pt,
                                            input logic [3:0] n);
    logic [15:0] g;
    logic [3:0]  mv;
    logic [3:0]  mp;
    logic [1:0]  src;
    g  = '0;
    mp = '0;
    for (int m = 0; m < 16; m++) begin
      mv = 4'(m);
      for (int i = 0; i < 4; i++) begin
        src   = pt[7-2*i -: 2];
        mp[i] = mv[src] ^ n[i];
      end
      g[m] = f[mp];
    end
    return g;
  endfunction

  state_t      state_q, state_d;
  logic        accept;
  logic        last_step;
  logic [8:0]  step_q;

  logic [15:0] tt_p0;
  logic [15:0] best_tt_p1;
  logic [4:0]  best_perm_p1;
  logic [3:0]  best_ineg_p1;
  logic        best_oneg_p1;

  logic [4:0]  cur_perm;
  logic [3:0]  cur_ineg;
  logic [15:0] cand0, cand1;
  logic [15:0] nb_tt;
  logic [4:0]  nb_perm;
  logic [3:0]  nb_ineg;
  logic        nb_oneg;

  assign in_ready  = (state_q == IDLE);
  assign busy      = (state_q == SEARCH);
  assign out_valid = (state_q == DONE);
  assign last_step = (step_q == LAST_STEP);
  assign cur_perm  = step_q[8:4];
  assign cur_ineg  = step_q[3:0];

  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          accept  = 1'b1;
          state_d = SEARCH;
        end
      end
      SEARCH: if (last_step) state_d = DONE;
      DONE:   if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Stage p0 -> p1: evaluate both polarities of the current step against the running best
  always_comb begin
    cand0   = npn_apply(tt_p0, perm_tuple(cur_perm), cur_ineg);
    cand1   = ~cand0;
    nb_tt   = best_tt_p1;
    nb_perm = best_perm_p1;
    nb_ineg = best_ineg_p1;
    nb_oneg = best_oneg_p1;
    if (cand0 < nb_tt) begin
      nb_tt   = cand0;
      nb_perm = cur_perm;
      nb_ineg = cur_ineg;
      nb_oneg = 1'b0;
    end
    if (cand1 < nb_tt) begin
      nb_tt   = cand1;
      nb_perm = cur_perm;
      nb_ineg = cur_ineg;
      nb_oneg = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      tt_p0        <= in_tt;
      best_tt_p1   <= in_tt;
      best_perm_p1 <= '0;
      best_ineg_p1 <= '0;
      best_oneg_p1 <= 1'b0;
    end else if (state_q == SEARCH) begin
      best_tt_p1   <= nb_tt;
      best_perm_p1 <= nb_perm;
      best_ineg_p1 <= nb_ineg;
      best_oneg_p1 <= nb_oneg;
    end
  end

  // Stage p1 -> result: outputs only move on the final step into DONE
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      step_q   <= '0;
      out_tt   <= '0;
      out_perm <= '0;
      out_ineg <= '0;
      out_oneg <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        step_q <= '0;
      end else if ((state_q == SEARCH) && !last_step) begin
        step_q <= step_q + 9'd1;
      end
      if ((state_q == SEARCH) && last_step) begin
        out_tt   <= nb_tt;
        out_perm <= nb_perm;
        out_ineg <= nb_ineg;
        out_oneg <= nb_oneg;
      end
    end
  end

endmodule

// File: tb/tb_npn4_canon_search.sv
// Directed bench for npn4_canon_search: known canonical forms, latency, backpressure, reset abort.
module tb_npn4_canon_search;

  logic        clk;
  logic        rst;
  logic [15:0] in_tt;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] out_tt;
  logic [4:0]  out_perm;
  logic [3:0]  out_ineg;
  logic        out_oneg;
  logic        out_valid;
  logic        out_ready;
  logic        busy;

  int n_checks = 0;
  int n_errors = 0;

  npn4_canon_search dut (
    .clk       (clk),
    .rst       (rst),
    .in_tt     (in_tt),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_tt    (out_tt),
    .out_perm  (out_perm),
    .out_ineg  (out_ineg),
    .out_oneg  (out_oneg),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Called #1 after a rising edge; returns #1 after the accept edge.
  task automatic start_accept(input logic [15:0] tt);
    in_tt    = tt;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_done(output int lat);
    lat = 0;
    while (!out_valid && lat < 1000) begin
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  task automatic release_result();
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
  endtask

  task automatic run_case(input string tag, input logic [15:0] tt, input logic [15:0] e_tt,
                          input logic [4:0] e_p, input logic [3:0] e_n, input logic e_o);
    int lat;
    start_accept(tt);
    wait_done(lat);
    check({tag, "_valid"}, 32'(out_valid), 32'd1);
    check({tag, "_tt"},    32'(out_tt),    32'(e_tt));
    check({tag, "_perm"},  32'(out_perm),  32'(e_p));
    check({tag, "_ineg"},  32'(out_ineg),  32'(e_n));
    check({tag, "_oneg"},  32'(out_oneg),  32'(e_o));
    release_result();
    check({tag, "_ready_after"}, 32'(in_ready), 32'd1);
  endtask

  initial begin
    int lat;
    int changes;
    rst       = 1'b1;
    in_tt     = '0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    #12;
    check("rst_in_ready",  32'(in_ready),  32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_busy",      32'(busy),      32'd0);
    check("rst_out_tt",    32'(out_tt),    32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Zero function, with exact latency and busy tracking
    start_accept(16'h0000);
    check("zero_busy",     32'(busy),     32'd1);
    check("zero_in_ready", 32'(in_ready), 32'd0);
    wait_done(lat);
    check("zero_latency", 32'(lat), 32'd384);
    check("zero_tt",   32'(out_tt),   32'h0000);
    check("zero_perm", 32'(out_perm), 32'd0);
    check("zero_ineg", 32'(out_ineg), 32'h0);
    check("zero_oneg", 32'(out_oneg), 32'd0);
    check("zero_busy_done", 32'(busy), 32'd0);
    release_result();
    check("zero_ready_after", 32'(in_ready), 32'd1);

    run_case("ones", 16'hFFFF, 16'h0000, 5'd0,  4'h0, 1'b1);
    run_case("x0",   16'hAAAA, 16'h00FF, 5'd18, 4'h0, 1'b1);

    // AND4 with input pulsed during SEARCH and DONE under backpressure
    start_accept(16'h8000);
    repeat (10) @(posedge clk);
    #1;
    in_tt    = 16'h1234;
    in_valid = 1'b1;
    check("bp_search_in_ready", 32'(in_ready), 32'd0);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    wait_done(lat);
    check("bp_valid", 32'(out_valid), 32'd1);
    changes = 0;
    for (int i = 0; i < 50; i++) begin
      @(posedge clk);
      #1;
      if (i == 20) begin
        in_tt    = 16'h1234;
        in_valid = 1'b1;
      end
      if (i == 25) in_valid = 1'b0;
      if (out_tt !== 16'h0001 || out_ineg !== 4'hF || out_valid !== 1'b1 || in_ready !== 1'b0)
        changes++;
    end
    check("bp_stable_cycles", 32'(changes), 32'd0);
    check("bp_tt",   32'(out_tt),   32'h0001);
    check("bp_perm", 32'(out_perm), 32'd0);
    check("bp_ineg", 32'(out_ineg), 32'hF);
    check("bp_oneg", 32'(out_oneg), 32'd0);
    release_result();
    check("bp_ready_after", 32'(in_ready),  32'd1);
    check("bp_valid_after", 32'(out_valid), 32'd0);
    check("bp_held_tt",     32'(out_tt),    32'h0001);
    @(posedge clk);
    #1;
    check("bp_not_accepted", 32'(busy), 32'd0);

    // Reset at step 200 of a parity search
    start_accept(16'h6996);
    repeat (200) @(posedge clk);
    #1;
    check("abort_busy_before", 32'(busy), 32'd1);
    rst = 1'b1;
    #1;
    check("abort_tt",       32'(out_tt),    32'd0);
    check("abort_ineg",     32'(out_ineg),  32'd0);
    check("abort_valid",    32'(out_valid), 32'd0);
    check("abort_busy",     32'(busy),      32'd0);
    check("abort_in_ready", 32'(in_ready),  32'd1);
    @(posedge clk);
    #1;
    rst = 1'b0;
    run_case("parity", 16'h6996, 16'h6996, 5'd0, 4'h0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
